// File: rtl/spgd_dither_sequencer.sv
// SPGD dither/measure/update sequencer; one iteration = 2*(SETTLE_CYC+1)+2*2^n+1 cycles, no backpressure (one ADC sample per cycle).
// Define SPGD_SEQ_LFSR_EN to draw the dither sign from a 16-bit LFSR instead of strict +/- alternation.
module spgd_dither_sequencer #(
    parameter int ADC_WIDTH    = 12,
    parameter int DAC_WIDTH    = 14,
    parameter int MAX_AVG_LOG2 = 10
) (
    input  logic                 ADC_CLK,
    input  logic                 RST,
    input  logic                 RUN,
    input  logic [ADC_WIDTH-1:0] ADC_DATA_IN,
    input  logic [15:0]          SETTLE_CYC,
    input  logic [3:0]           AVG_LOG2_IN,
    input  logic [DAC_WIDTH-1:0] DELTA,
    input  logic [4:0]           GAIN_SHIFT,
    output logic [DAC_WIDTH-1:0] DAC_CODE_OUT,
    output logic [ADC_WIDTH-1:0] J_OUT,
    output logic                 ITER_DONE,
    output logic                 BUSY,
    output logic [15:0]          ITER_CNT
);
    localparam int ACC_W = ADC_WIDTH + MAX_AVG_LOG2;
    localparam int DIF_W = ACC_W + 1;
    localparam int INT_W = DAC_WIDTH + 10;
    localparam logic [DAC_WIDTH-1:0] DAC_MID = {1'b1, {(DAC_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE_P,
        S_ACC_P,
        S_SETTLE_M,
        S_ACC_M,
        S_UPDATE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [1:0]              r_rst_sync;
    logic                    w_rst_n;
    logic [15:0]             r_settle;
    logic [3:0]              r_n;
    logic [DAC_WIDTH-1:0]    r_delta;
    logic [4:0]              r_gshift;
    logic                    r_neg;
    logic [15:0]             r_cnt;
    logic [ACC_W-1:0]        r_acc_p;
    logic [ACC_W-1:0]        r_acc_m;
    logic [DAC_WIDTH-1:0]    r_base;
    logic [DAC_WIDTH-1:0]    r_dac;
    logic [ADC_WIDTH-1:0]    r_j;
    logic                    r_done;
    logic                    r_busy;
    logic [15:0]             r_iter_cnt;

    logic                    w_start;
    logic                    w_start_neg;
    logic                    w_cnt_zero;
    logic [3:0]              w_n_in;
    logic [15:0]             w_win_last;
    logic signed [DIF_W-1:0] w_diff;
    logic [5:0]              w_shamt;
    logic signed [DIF_W-1:0] w_step;
    logic signed [INT_W-1:0] w_step_ext;
    logic signed [INT_W-1:0] w_base_ext;
    logic signed [INT_W-1:0] w_base_sum;
    logic [DAC_WIDTH-1:0]    w_base_new;
    logic [DIF_W-1:0]        w_jsum;
    logic [DAC_WIDTH-1:0]    w_base_start;

    // Reset asserts immediately, releases two ADC_CLK edges after RST rises.
    always_ff @(posedge ADC_CLK or negedge RST) begin
        if (!RST) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    function automatic logic [DAC_WIDTH-1:0] sat(input logic signed [INT_W-1:0] v);
        logic [DAC_WIDTH-1:0] res;
        if (v[INT_W-1]) begin
            res = '0;
        end else if (|v[INT_W-2:DAC_WIDTH]) begin
            res = '1;
        end else begin
            res = v[DAC_WIDTH-1:0];
        end
        return res;
    endfunction

    function automatic logic [DAC_WIDTH-1:0] pert(input logic [DAC_WIDTH-1:0] base,
                                                   input logic [DAC_WIDTH-1:0] dlt,
                                                   input logic                 neg);
        logic signed [INT_W-1:0] b;
        logic signed [INT_W-1:0] d;
        b = signed'(INT_W'(base));
        d = signed'(INT_W'(dlt));
        return sat(neg ? (b - d) : (b + d));
    endfunction

    assign w_n_in     = (AVG_LOG2_IN > 4'(MAX_AVG_LOG2)) ? 4'(MAX_AVG_LOG2) : AVG_LOG2_IN;
    assign w_win_last = 16'((17'd1 << r_n) - 17'd1);
    assign w_cnt_zero = (r_cnt == 16'd0);
    assign w_start    = RUN && ((r_state == S_IDLE) || (r_state == S_UPDATE));

    // Gradient step: positive diff means the +s side scored higher, so move along s.
    assign w_diff     = $signed({1'b0, r_acc_p}) - $signed({1'b0, r_acc_m});
    assign w_shamt    = 6'(r_n) + 6'(r_gshift);
    assign w_step     = w_diff >>> w_shamt;
    assign w_step_ext = $signed({{(INT_W-DIF_W){w_step[DIF_W-1]}}, w_step});
    assign w_base_ext = signed'(INT_W'(r_base));
    assign w_base_sum = r_neg ? (w_base_ext - w_step_ext) : (w_base_ext + w_step_ext);
    assign w_base_new = sat(w_base_sum);
    assign w_jsum     = {1'b0, r_acc_p} + {1'b0, r_acc_m};

    assign w_base_start = (r_state == S_UPDATE) ? w_base_new : r_base;

`ifdef SPGD_SEQ_LFSR_EN
    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb        = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_start_neg = ~r_lfsr[0];

    always_ff @(posedge ADC_CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_lfsr <= 16'hACE1;
        end else if (w_start) begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end
`else
    assign w_start_neg = (r_state == S_IDLE) ? 1'b0 : ~r_neg;
`endif

    always_ff @(posedge ADC_CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:     if (RUN) w_state_nxt = S_SETTLE_P;
            S_SETTLE_P: begin
                if (!RUN)           w_state_nxt = S_IDLE;
                else if (w_cnt_zero) w_state_nxt = S_ACC_P;
            end
            S_ACC_P: begin
                if (!RUN)           w_state_nxt = S_IDLE;
                else if (w_cnt_zero) w_state_nxt = S_SETTLE_M;
            end
            S_SETTLE_M: begin
                if (!RUN)           w_state_nxt = S_IDLE;
                else if (w_cnt_zero) w_state_nxt = S_ACC_M;
            end
            S_ACC_M: begin
                if (!RUN)           w_state_nxt = S_IDLE;
                else if (w_cnt_zero) w_state_nxt = S_UPDATE;
            end
            S_UPDATE:   w_state_nxt = RUN ? S_SETTLE_P : S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ADC_CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_settle   <= '0;
            r_n        <= '0;
            r_delta    <= '0;
            r_gshift   <= '0;
            r_neg      <= 1'b0;
            r_cnt      <= '0;
            r_acc_p    <= '0;
            r_acc_m    <= '0;
            r_base     <= DAC_MID;
            r_dac      <= DAC_MID;
            r_j        <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_iter_cnt <= '0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_UPDATE);

            unique case (r_state)
                S_SETTLE_P, S_SETTLE_M: begin
                    if (!RUN) begin
                        r_dac <= r_base;
                    end else if (w_cnt_zero) begin
                        r_cnt <= w_win_last;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_ACC_P: begin
                    if (!RUN) begin
                        r_dac <= r_base;
                    end else begin
                        r_acc_p <= r_acc_p + ACC_W'(ADC_DATA_IN);
                        if (w_cnt_zero) begin
                            r_cnt <= r_settle;
                            r_dac <= pert(r_base, r_delta, ~r_neg);
                        end else begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                end
                S_ACC_M: begin
                    if (!RUN) begin
                        r_dac <= r_base;
                    end else begin
                        r_acc_m <= r_acc_m + ACC_W'(ADC_DATA_IN);
                        r_cnt   <= r_cnt - 16'd1;
                    end
                end
                S_UPDATE: begin
                    r_base     <= w_base_new;
                    r_j        <= ADC_WIDTH'(w_jsum >> (6'(r_n) + 6'd1));
                    r_iter_cnt <= r_iter_cnt + 16'd1;
                    if (!RUN) r_dac <= w_base_new;
                end
                default: ;
            endcase

            // Iteration start overrides: latch the iteration config from the live inputs.
            if (w_start) begin
                r_settle <= SETTLE_CYC;
                r_n      <= w_n_in;
                r_delta  <= DELTA;
                r_gshift <= GAIN_SHIFT;
                r_neg    <= w_start_neg;
                r_cnt    <= SETTLE_CYC;
                r_acc_p  <= '0;
                r_acc_m  <= '0;
                r_dac    <= pert(w_base_start, DELTA, w_start_neg);
            end
        end
    end

    assign DAC_CODE_OUT = r_dac;
    assign J_OUT        = r_j;
    assign ITER_DONE    = r_done;
    assign BUSY         = r_busy;
    assign ITER_CNT     = r_iter_cnt;

endmodule

// File: tb/tb_spgd_dither_sequencer.sv
// Scoreboard bench for spgd_dither_sequencer: stimulus queues expected per-iteration results, a negedge monitor checks them.
module tb_spgd_dither_sequencer;
    typedef struct {
        int dac_m;
        int j;
        int cnt;
        int dac_next;
        int period;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [11:0] adc;
    logic [15:0] settle = 16'd3;
    logic [3:0]  avg = 4'd2;
    logic [13:0] delta = 14'd64;
    logic [4:0]  gsh = 5'd0;
    logic [13:0] dac;
    logic [11:0] j;
    logic        done;
    logic        busy;
    logic [15:0] icnt;
    logic        plant_lin = 1'b0;
    logic [11:0] adc_const = 12'h400;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_ev = 0;
    bit pend = 0;
    bit prev_busy = 0;
    rec_t cur;
    rec_t q_iter[$];
    int   q_start[$];

    int          m_base = 8192;
    int          m_prev_s = 1;
    logic [15:0] m_lfsr = 16'hACE1;

    always #5 clk = ~clk;

    assign adc = plant_lin ? 12'(dac >> 2) : adc_const;

    spgd_dither_sequencer dut (
        .ADC_CLK      (clk),
        .RST          (rst_n),
        .RUN          (run),
        .ADC_DATA_IN  (adc),
        .SETTLE_CYC   (settle),
        .AVG_LOG2_IN  (avg),
        .DELTA        (delta),
        .GAIN_SHIFT   (gsh),
        .DAC_CODE_OUT (dac),
        .J_OUT        (j),
        .ITER_DONE    (done),
        .BUSY         (busy),
        .ITER_CNT     (icnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int sat_m(input int v);
        return (v < 0) ? 0 : ((v > 16383) ? 16383 : v);
    endfunction

    task automatic next_sign(input bit from_idle, output int s);
`ifdef SPGD_SEQ_LFSR_EN
        s = m_lfsr[0] ? 1 : -1;
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        if (from_idle) m_prev_s = s;
`else
        s = from_idle ? 1 : -m_prev_s;
`endif
        m_prev_s = s;
    endtask

    task automatic wait_done(input int lim);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < lim);
        chk("iter_done_seen", int'(done), 1);
    endtask

    // Constant-ADC run: base must not move, so every DAC code follows from the sign sequence.
    task automatic run_iters(input int n_it, input int d, input int exp_j, input int p_first,
                             input int p_rest, input bit tweak);
        int s[8];
        rec_t r;
        for (int k = 0; k < n_it; k++) next_sign(k == 0, s[k]);
        q_start.push_back(sat_m(m_base + s[0] * d));
        for (int k = 0; k < n_it; k++) begin
            r.dac_m    = sat_m(m_base - s[k] * d);
            r.j        = exp_j;
            r.cnt      = (int'(icnt) + k + 1) & 16'hFFFF;
            r.dac_next = (k < n_it - 1) ? sat_m(m_base + s[k+1] * d) : m_base;
            r.period   = (k == 0) ? p_first : p_rest;
            q_iter.push_back(r);
        end
        delta = 14'(d);
        run = 1'b1;
        if (tweak) begin
            repeat (3) @(negedge clk);
            settle = 16'd9;
        end
        for (int k = 0; k < n_it; k++) begin
            wait_done(p_first + 10);
            if (k == 0) settle = 16'd3;
        end
        run = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pend) begin
            pend = 0;
            chk("j_out", int'(j), cur.j);
            chk("iter_cnt", int'(icnt), cur.cnt);
            chk("dac_after_update", int'(dac), cur.dac_next);
        end
        if (rst_n && busy && !prev_busy) begin
            last_ev = cyc;
            chk("start_expected", int'(q_start.size() > 0), 1);
            if (q_start.size() > 0) chk("dac_plus_first", int'(dac), q_start.pop_front());
        end
        if (rst_n && done) begin
            chk("iter_expected", int'(q_iter.size() > 0), 1);
            if (q_iter.size() > 0) begin
                cur = q_iter.pop_front();
                chk("dac_minus_phase", int'(dac), cur.dac_m);
                chk("iter_period", cyc - last_ev, cur.period);
                pend = 1;
            end
            last_ev = cyc;
        end
        prev_busy = busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        repeat (3) @(negedge clk);
        chk("rst_dac", int'(dac), 8192);
        chk("rst_j", int'(j), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt", int'(icnt), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Constant plant, 17-cycle period; SETTLE_CYC disturbed mid-iteration must not matter.
        run_iters(4, 64, 12'h400, 16, 17, 1'b1);

`ifndef SPGD_SEQ_LFSR_EN
        plant_lin = 1'b1;
        q_start.push_back(8256);
        q_iter.push_back(rec_t'{8128, 2048, 5, 8160, 16});
        q_iter.push_back(rec_t'{8288, 2056, 6, 8256, 17});
        delta = 14'd64;
        run = 1'b1;
        wait_done(40);
        wait_done(40);
        run = 1'b0;
        next_sign(1'b1, s);
        next_sign(1'b0, s);
        m_base = 8256;
        repeat (3) @(negedge clk);
        plant_lin = 1'b0;
`endif

        // Asynchronous reset in the middle of ACC_M.
        next_sign(1'b1, s);
        q_start.push_back(sat_m(m_base + s * 100));
        delta = 14'd100;
        run = 1'b1;
        @(posedge clk);
        repeat (13) @(posedge clk);
        #1;
        chk("busy_mid_accm", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dac", int'(dac), 8192);
        chk("arst_j", int'(j), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_cnt", int'(icnt), 0);
        run = 1'b0;
        m_base = 8192;
        m_lfsr = 16'hACE1;
        m_prev_s = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Full-scale delta: both perturbed codes saturate.
        run_iters(1, 16383, 12'h400, 16, 17, 1'b0);

        // AVG_LOG2_IN above the maximum clamps to 1024-sample windows.
        avg = 4'd15;
        settle = 16'd0;
        run_iters(1, 64, 12'h400, 2050, 2051, 1'b0);
        avg = 4'd2;
        settle = 16'd3;

        // Abort during the third ACC_P cycle.
        next_sign(1'b1, s);
        q_start.push_back(sat_m(m_base + s * 64));
        delta = 14'd64;
        run = 1'b1;
        @(posedge clk);
        repeat (6) @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_dac", int'(dac), 8192);
        chk("abort_cnt", int'(icnt), 2);
        chk("abort_done", int'(done), 0);
        repeat (20) @(negedge clk);
        chk("abort_cnt_hold", int'(icnt), 2);

        chk("iter_queue_drained", q_iter.size(), 0);
        chk("start_queue_drained", q_start.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spgd_dither_sequencer.md
# spgd_dither_sequencer

Iteration sequencer for the SPGD loop, running in the ADC_CLK domain. It dithers the DAC code around a working point with signed perturbations (+s·δ, then −s·δ). After each perturbation it waits a settle interval and averages 2^n ADC samples. It then moves the working point along the measured gradient, so the ADC metric is maximised. It replaces free-running averaging windows with a deterministic, restartable measure/update schedule.

## Interface
- ADC_WIDTH, 12, ADC sample width; samples are unsigned.
- DAC_WIDTH, 14, DAC code width; codes are unsigned offset binary.
- MAX_AVG_LOG2, 10, largest averaging exponent n; the window is at most 1024 samples.
- ADC_CLK  in  1  sole clock; all logic is rising-edge.
- RST  in  1  asynchronous, active-low reset.
- RUN  in  1  enable, taken from GP_IN[31]; level-sensitive.
- ADC_DATA_IN  in  ADC_WIDTH  ADC sample, valid every cycle.
- SETTLE_CYC  in  16  settle cycles after each DAC step, minus one.
- AVG_LOG2_IN  in  4  averaging exponent n; values above MAX_AVG_LOG2 clamp to MAX_AVG_LOG2.
- DELTA  in  DAC_WIDTH  perturbation amplitude δ.
- GAIN_SHIFT  in  5  extra right shift applied to the gradient step.
- DAC_CODE_OUT  out  DAC_WIDTH  registered DAC code.
- J_OUT  out  ADC_WIDTH  mean metric of the last iteration.
- ITER_DONE  out  1  one-cycle pulse, high during UPDATE.
- BUSY  out  1  high in every state except IDLE.
- ITER_CNT  out  16  completed iterations; wraps at 0xFFFF→0.

## Operation
- States: IDLE → SETTLE_P → ACC_P → SETTLE_M → ACC_M → UPDATE → (SETTLE_P if RUN, else IDLE).
- Reset values:
  - DAC_CODE_OUT and base = 2^(DAC_WIDTH−1) = 8192.
  - J_OUT = 0, ITER_DONE = 0, BUSY = 0, ITER_CNT = 0.
  - Accumulators = 0, sign s = +1, LFSR = 16'hACE1.
- Iteration start: the IDLE→SETTLE_P or UPDATE→SETTLE_P edge does the following.
  - Latches SETTLE_CYC, the clamped n, DELTA and GAIN_SHIFT; these are held constant for the whole iteration.
  - Picks s for the iteration.
  - Clears both accumulators.
  - Loads DAC_CODE_OUT = sat(base + s·δ).
- SETTLE_x: lasts SETTLE_CYC+1 cycles. A settle counter counts down; no samples are taken.
- ACC_P / ACC_M: last exactly 2^n cycles. ADC_DATA_IN is zero-extended and added every cycle.
  - Accumulator width is ADC_WIDTH+MAX_AVG_LOG2 (22 bits); it cannot overflow.
- SETTLE_P→ACC_P→SETTLE_M edge: DAC_CODE_OUT = sat(base − s·δ).
- UPDATE (1 cycle) computes the following.
  - diff = acc_p − acc_m, signed, 23 bits.
  - step = diff >>> (n + GAIN_SHIFT), arithmetic shift.
  - base ← sat(base + s·step).
  - J_OUT ← (acc_p + acc_m) >> (n+1).
  - ITER_CNT increments.
- sat() clamps to [0, 2^DAC_WIDTH − 1]. Intermediates are computed at DAC_WIDTH+10 bits, signed.
- RUN low in any non-IDLE state aborts the iteration.
  - The next edge goes to IDLE and DAC_CODE_OUT ← base.
  - The aborted iteration leaves base, J_OUT and ITER_CNT unchanged, and ITER_DONE does not pulse.
  - RUN low during UPDATE: the update completes, then the FSM goes to IDLE.
- In IDLE, DAC_CODE_OUT holds base.
- Reset asserted mid-iteration returns everything to the reset values immediately (asynchronous). Reset release is synchronised internally with a 2-flop deassert.

## Timing
- RUN high in IDLE: SETTLE_P is entered on the next edge, and DAC_CODE_OUT changes at that same edge.
- Iteration length while RUN stays high: 2·(SETTLE_CYC+1) + 2·2^n + 1 cycles, measured between ITER_DONE pulses.
- DAC_CODE_OUT changes only at iteration start, at ACC_P→SETTLE_M, and at UPDATE exit or abort. It is glitch-free (registered).
- New base is visible on DAC_CODE_OUT one cycle after UPDATE, offset by the next iteration's perturbation.
- A SETTLE_CYC change is ignored until the next iteration start.

## Configuration
- SPGD_SEQ_LFSR_EN defined: s comes from bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11), advanced once per iteration start. Bit 0 = 1 → s = +1.
- SPGD_SEQ_LFSR_EN undefined: s alternates deterministically, +1 on the first iteration after reset or IDLE, then −1, +1, …; the LFSR is not instantiated.

## Test plan
- Constant ADC = 0x400, SETTLE_CYC=3, n=2, macro off:
  - ITER_DONE period is 17 cycles.
  - base stays 8192; J_OUT = 0x400.
  - ITER_CNT counts 1, 2, 3, …
- Linear plant ADC = DAC_CODE_OUT>>2, δ=64, GAIN_SHIFT=0, n=2, macro off:
  - Iteration 1 drives DAC 8256, then 8128; base becomes 8224.
  - Iteration 2 (s=−1) drives DAC 8160, then 8288; base becomes 8256.
- Saturation, δ=16383, base 8192, macro off: DAC_CODE_OUT = 16383 in the +δ phase and 0 in the −δ phase.
- RUN dropped on the 3rd ACC_P cycle:
  - IDLE on the next edge; DAC_CODE_OUT returns to 8192.
  - No ITER_DONE; ITER_CNT unchanged; BUSY = 0.
- RST pulsed low mid-ACC_M: all outputs return to their reset values within the same cycle, with no clock edge needed.
- Macro on, constant ADC: the sign sequence matches the LFSR model seeded with 0xACE1, and base stays 8192.
